imm_gen_pipe: RTL and testbench

//   Registered, parametrised immediate generator for the decode stage. Extracts
//   and sign/zero-extends the RISC-V immediate from instr[31:7] to XLEN bits.

---
 rtl/imm_pkg.sv | 15 +
 rtl/imm_format.sv | 31 +++
 rtl/imm_gen_pipe.sv | 85 ++++++++
 tb/tb_imm_gen_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: immediate format codes and skid-buffer state encodings for imm_gen_pipe
package imm_pkg;
  localparam logic [2:0] IMM_I  = 3'b000;
  localparam logic [2:0] IMM_B  = 3'b001;
  localparam logic [2:0] IMM_S  = 3'b010;
  localparam logic [2:0] IMM_U  = 3'b011;
  localparam logic [2:0] IMM_J  = 3'b100;
  localparam logic [2:0] IMM_Z  = 3'b101;
  localparam logic [2:0] IMM_SH = 3'b110;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;
endpackage

// File: rtl/imm_format.sv
// imm_format: combinational RISC-V immediate extraction from instr[31:7]; Z-type enabled by IMM_ZICSR_EN
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [24:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  // instr[k] holds architectural bit k+7
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:  imm = {{(XLEN-11){instr[24]}}, instr[23:13]};
      IMM_B:  imm = {{(XLEN-12){instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      IMM_S:  imm = {{(XLEN-11){instr[24]}}, instr[23:18], instr[4:0]};
      IMM_U:  imm = {{(XLEN-31){instr[24]}}, instr[23:5], 12'b0};
      IMM_J:  imm = {{(XLEN-20){instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      IMM_SH: imm = XLEN == 64 ? XLEN'(instr[18:13]) : XLEN'(instr[17:13]);
`ifdef IMM_ZICSR_EN
      IMM_Z:  imm = XLEN'(instr[12:8]);
`else
      IMM_Z:  illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a 2-entry skid buffer; Z-type via IMM_ZICSR_EN
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  state_e          state_q, state_d;
  ent_t            out_q, out_d, skid_q, skid_d, in_ent;
  logic [XLEN-1:0] fmt_imm;
  logic            fmt_ill, acc, deq;

  imm_format #(.XLEN(XLEN)) u_fmt (
    .instr   (in_instr),
    .imm_src (in_imm_src),
    .imm     (fmt_imm),
    .illegal (fmt_ill)
  );

  assign in_ent = {fmt_imm, in_tag, fmt_ill};
  assign acc    = in_valid & in_ready;
  assign deq    = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = flush                ? ST_EMPTY :
              state_q == ST_EMPTY  ? (acc ? ST_FULL : ST_EMPTY) :
              state_q == ST_FULL   ? (acc & ~deq ? ST_SKID : deq & ~acc ? ST_EMPTY : ST_FULL) :
                                     (deq ? ST_FULL : ST_SKID);
  end

  always_comb begin
    in_ready  = state_q != ST_SKID;
    out_valid = state_q != ST_EMPTY;
  end

  // Output register refills from skid first so ordering stays FIFO
  always_comb begin
    out_d  = out_q;
    skid_d = skid_q;
    if (!flush) begin
      if (state_q == ST_SKID && deq)                   out_d  = skid_q;
      else if (acc && (state_q == ST_EMPTY || deq))    out_d  = in_ent;
      if (state_q == ST_FULL && acc && !deq)           skid_d = in_ent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_q  <= out_d;
      skid_q <= skid_d;
    end
  end

  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: random + directed check of imm_gen_pipe (XLEN 32 and 64) against a queue model
module tb_imm_gen_pipe;
  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  src = '0;
  logic [4:0]  tag = '0;
  logic        rdy32, rdy64, ov32, ov64, il32, il64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tg32, tg64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(instr[31:7]), .in_imm_src(src), .in_tag(tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tg32), .out_illegal(il32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(instr[31:7]), .in_imm_src(src), .in_tag(tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tg64), .out_illegal(il64));

  typedef struct {
    logic [63:0] i32;
    logic [63:0] i64;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int b);
    logic [63:0] m = 64'd1 << (b - 1);
    return (v ^ m) - m;
  endfunction

  // Immediate as the ISA defines it, as a value of the given width
  function automatic void ref_imm(input logic [31:0] x, input logic [2:0] s, input int xl,
                                  output logic [63:0] imm, output logic ill);
    ill = 1'b0;
    imm = '0;
    case (s)
      3'd0: imm = sx(64'(x[31:20]), 12);
      3'd1: imm = sx(64'({x[31], x[7], x[30:25], x[11:8], 1'b0}), 13);
      3'd2: imm = sx(64'({x[31:25], x[11:7]}), 12);
      3'd3: imm = sx(64'(x & 32'hFFFF_F000), 32);
      3'd4: imm = sx(64'({x[31], x[19:12], x[20], x[30:21], 1'b0}), 21);
      3'd6: imm = xl == 32 ? 64'(x[24:20]) : 64'(x[25:20]);
`ifdef IMM_ZICSR_EN
      3'd5: imm = 64'(x[19:15]);
`endif
      default: ill = 1'b1;
    endcase
    if (xl == 32) imm = {32'b0, imm[31:0]};
  endfunction

  task automatic check_all();
    logic m_rdy = q.size() < 2;
    logic m_ov  = q.size() > 0;
    chk("in_ready32", 64'(rdy32), 64'(m_rdy));
    chk("in_ready64", 64'(rdy64), 64'(m_rdy));
    chk("out_valid32", 64'(ov32), 64'(m_ov));
    chk("out_valid64", 64'(ov64), 64'(m_ov));
    if (m_ov) begin
      chk("out_imm32", 64'(imm32), q[0].i32);
      chk("out_imm64", imm64, q[0].i64);
      chk("out_tag32", 64'(tg32), 64'(q[0].tag));
      chk("out_tag64", 64'(tg64), 64'(q[0].tag));
      chk("out_ill32", 64'(il32), 64'(q[0].ill));
      chk("out_ill64", 64'(il64), 64'(q[0].ill));
    end
  endtask

  task automatic cycle(output logic accepted);
    logic m_rdy = q.size() < 2;
    logic m_ov  = q.size() > 0;
    ent_t e;
    accepted = 1'b0;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (m_ov && out_ready) void'(q.pop_front());
      if (in_valid && m_rdy) begin
        ref_imm(instr, src, 32, e.i32, e.ill);
        ref_imm(instr, src, 64, e.i64, e.ill);
        e.tag = tag;
        q.push_back(e);
        accepted = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    #1;
    chk("rst_valid32", 64'(ov32), 64'd0);
    chk("rst_ready32", 64'(rdy32), 64'd1);
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_tag32", 64'(tg32), 64'd0);
    chk("rst_ill32", 64'(il32), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_valid64", 64'(ov64), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_one(input logic [31:0] x, input logic [2:0] s, input logic [4:0] t);
    logic a;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    instr     = x;
    src       = s;
    tag       = t;
    cycle(a);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle(a);
  endtask

  initial begin
    logic [63:0] m;
    logic        mi, a;
    // Model pinned to hand-computed values
    ref_imm(32'hFFF0_0093, 3'd0, 32, m, mi);
    chk("model_I", m, 64'hFFFF_FFFF);
    ref_imm(32'hFE00_0EE3, 3'd1, 32, m, mi);
    chk("model_B_m4", m, 64'hFFFF_FFFC);
    ref_imm(32'hFE00_0FE3, 3'd1, 32, m, mi);
    chk("model_B_m2", m, 64'hFFFF_FFFE);
    ref_imm(32'h8000_00B7, 3'd3, 64, m, mi);
    chk("model_U64", m, 64'hFFFF_FFFF_8000_0000);
    ref_imm(32'h1234_5678, 3'd7, 32, m, mi);
    chk("model_ill_imm", m, 64'd0);
    chk("model_ill_flag", 64'(mi), 64'd1);

    do_reset();

    send_one(32'hFFF0_0093, 3'd0, 5'd1);
    chk("I_imm32", 64'(imm32), 64'hFFFF_FFFF);
    chk("I_ill32", 64'(il32), 64'd0);
    chk("I_valid_lat1", 64'(ov32), 64'd1);
    drain();
    send_one(32'hFE00_0EE3, 3'd1, 5'd2);
    chk("B_imm32", 64'(imm32), 64'hFFFF_FFFC);
    drain();
    send_one(32'h8000_00B7, 3'd3, 5'd3);
    chk("U_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    drain();
    send_one(32'h1234_5678, 3'd7, 5'd4);
    chk("src7_imm", 64'(imm32), 64'd0);
    chk("src7_ill", 64'(il32), 64'd1);
    drain();
    send_one(32'h0002_D073, 3'd5, 5'd5);
`ifdef IMM_ZICSR_EN
    chk("Z_imm", 64'(imm32), 64'd5);
    chk("Z_ill", 64'(il32), 64'd0);
`else
    chk("Z_imm", 64'(imm32), 64'd0);
    chk("Z_ill", 64'(il32), 64'd1);
`endif
    drain();

    // Back-to-back input with consumer stalled for 3 cycles
    tag = 5'd10;
    out_ready = 1'b0;
    in_valid = 1'b1;
    src = 3'd0;
    for (int k = 0; k < 3; k++) begin
      instr = $urandom;
      cycle(a);
      if (a) tag = tag + 5'd1;
    end
    chk("bp_in_ready", 64'(rdy32), 64'd0);
    chk("bp_head_tag", 64'(tg32), 64'd10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle(a);
    chk("bp_second_tag", 64'(tg32), 64'd11);
    drain();

    // Reach SKID then flush with a colliding input
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tag = 5'(20 + k);
      instr = $urandom;
      cycle(a);
    end
    chk("skid_ready", 64'(rdy32), 64'd0);
    flush = 1'b1;
    tag = 5'd31;
    cycle(a);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(ov32), 64'd0);
    chk("flush_ready", 64'(rdy32), 64'd1);
    drain();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        flush     = $urandom_range(0, 39) == 0;
        in_valid  = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 2) != 0;
        instr     = $urandom;
        src       = 3'($urandom_range(0, 7));
        tag       = 5'($urandom);
        cycle(a);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
